// File: rtl/aes_gcm_pkg.sv
// Shared types and helpers for the AES-GCM host stream source.
// Holds the FSM encoding, block geometry, the keep-mask helper and the length-to-blocks helper.
package aes_gcm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AAD   = 2'd1,
        ST_PLD   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int BLK_BYTES = 16;
    localparam logic [BLK_BYTES-1:0] KEEP_FULL = '1;

    // Residual byte count of the final block -> byte-valid mask, byte 0 in the MSB.
    function automatic logic [BLK_BYTES-1:0] keep_from_resid(input logic [3:0] resid);
        logic [BLK_BYTES-1:0] k;
        if (resid == 4'd0) begin
            k = KEEP_FULL;
        end else begin
            k = KEEP_FULL << (5'(BLK_BYTES) - {1'b0, resid});
        end
        return k;
    endfunction

    // Bit length -> number of 128-bit blocks, computed 65 bits wide so the round-up cannot wrap.
    function automatic logic [57:0] len_to_blocks(input logic [63:0] len_bits);
        logic [64:0] sum;
        sum = {1'b0, len_bits} + 65'd127;
        return sum[64:7];
    endfunction

endpackage

// File: rtl/aes_gcm_src_obuf.sv
// Single-entry valid/ready output register that steers one beat to either the AAD or payload port.
// With AES_GCM_SRC_MASK_EN defined, bytes whose keep bit is clear are zeroed as the beat is loaded.
module aes_gcm_src_obuf
    import aes_gcm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_data,
    input  logic [BLK_BYTES-1:0]   in_keep,
    input  logic                   in_last,
    input  logic                   in_sel_aad,
    input  logic                   aad_ready,
    input  logic                   din_ready,
    output logic                   aad_valid,
    output logic                   din_valid,
    output logic [127:0]           out_data,
    output logic [BLK_BYTES-1:0]   out_keep,
    output logic                   out_last,
    output logic                   out_sel_aad,
    output logic                   drained
);

    logic                 valid_q, valid_d;
    logic [127:0]         data_q, data_d;
    logic [BLK_BYTES-1:0] keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 sel_q, sel_d;
    logic                 tgt_ready;
    logic [127:0]         in_masked;

    always_comb begin
        in_masked = in_data;
`ifdef AES_GCM_SRC_MASK_EN
        for (int b = 0; b < BLK_BYTES; b++) begin
            if (!in_keep[b]) begin
                in_masked[b*8 +: 8] = 8'h00;
            end
        end
`endif
    end

    assign tgt_ready = sel_q ? aad_ready : din_ready;
    assign in_ready  = !valid_q || tgt_ready;
    assign drained   = !valid_q || tgt_ready;

    // Contents only change on a load, so a stalled beat stays stable while waiting for ready.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        sel_d   = sel_q;
        if (clr) begin
            valid_d = 1'b0;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
            sel_d   = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_masked;
            keep_d  = in_keep;
            last_d  = in_last;
            sel_d   = in_sel_aad;
        end else if (valid_q && tgt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign aad_valid   = valid_q && sel_q;
    assign din_valid   = valid_q && !sel_q;
    assign out_data    = data_q;
    assign out_keep    = keep_q;
    assign out_last    = last_q;
    assign out_sel_aad = sel_q;

endmodule

// File: rtl/aes_gcm_stream_src.sv
// Splits one aligned upstream stream into the GCM engine's AAD and payload streams with last/keep.
// Optional build macro AES_GCM_SRC_MASK_EN zeroes padding bytes on aad_data/din_data.
module aes_gcm_stream_src
    import aes_gcm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [63:0]  len_aad_bits,
    input  logic [63:0]  len_pld_bits,
    output logic         busy,
    output logic         done,
    output logic         len_err,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         aad_valid,
    input  logic         aad_ready,
    output logic         aad_last,
    output logic [127:0] aad_data,
    output logic [15:0]  aad_keep,
    output logic         din_valid,
    input  logic         din_ready,
    output logic         din_last,
    output logic [127:0] din_data,
    output logic [15:0]  din_keep
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     aad_n_q, aad_n_d, pld_n_q, pld_n_d;
    logic [BLK_BYTES-1:0] aad_klast_q, aad_klast_d, pld_klast_q, pld_klast_d;
    logic                 busy_q, busy_d, done_q, done_d, len_err_q, len_err_d;

    logic [57:0]          aad_nblk, pld_nblk;
    logic                 len_bad, phase_act, s_fire, beat_last;
    logic [BLK_BYTES-1:0] beat_keep;
    logic                 ob_in_ready, ob_drained, ob_last, ob_sel_aad;
    logic [127:0]         ob_data;
    logic [BLK_BYTES-1:0] ob_keep;

    assign aad_nblk = len_to_blocks(len_aad_bits);
    assign pld_nblk = len_to_blocks(len_pld_bits);
    assign len_bad  = (|len_aad_bits[2:0]) || (|len_pld_bits[2:0]) ||
                      (|(aad_nblk >> CNT_W)) || (|(pld_nblk >> CNT_W));

    assign phase_act = (state_q == ST_AAD) || (state_q == ST_PLD);
    assign s_ready   = phase_act && ob_in_ready;
    assign s_fire    = s_valid && s_ready;

    // A counter value of one marks the final block of the active phase.
    assign beat_last = (state_q == ST_AAD) ? (aad_n_q == ONE) : (pld_n_q == ONE);
    assign beat_keep = !beat_last ? KEEP_FULL :
                       (state_q == ST_AAD) ? aad_klast_q : pld_klast_q;

    aes_gcm_src_obuf u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (abort),
        .in_valid    (s_valid && phase_act),
        .in_ready    (ob_in_ready),
        .in_data     (s_data),
        .in_keep     (beat_keep),
        .in_last     (beat_last),
        .in_sel_aad  (state_q == ST_AAD),
        .aad_ready   (aad_ready),
        .din_ready   (din_ready),
        .aad_valid   (aad_valid),
        .din_valid   (din_valid),
        .out_data    (ob_data),
        .out_keep    (ob_keep),
        .out_last    (ob_last),
        .out_sel_aad (ob_sel_aad),
        .drained     (ob_drained)
    );

    always_comb begin
        state_d     = state_q;
        aad_n_d     = aad_n_q;
        pld_n_d     = pld_n_q;
        aad_klast_d = aad_klast_q;
        pld_klast_d = pld_klast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        len_err_d   = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            aad_n_d     = '0;
            pld_n_d     = '0;
            aad_klast_d = '0;
            pld_klast_d = '0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len_bad) begin
                            len_err_d = 1'b1;
                        end else begin
                            busy_d      = 1'b1;
                            aad_n_d     = aad_nblk[CNT_W-1:0];
                            pld_n_d     = pld_nblk[CNT_W-1:0];
                            aad_klast_d = keep_from_resid(len_aad_bits[6:3]);
                            pld_klast_d = keep_from_resid(len_pld_bits[6:3]);
                            if (aad_nblk != '0) begin
                                state_d = ST_AAD;
                            end else if (pld_nblk != '0) begin
                                state_d = ST_PLD;
                            end else begin
                                state_d = ST_FLUSH;
                            end
                        end
                    end
                end
                ST_AAD: begin
                    if (s_fire) begin
                        aad_n_d = aad_n_q - ONE;
                        if (aad_n_q == ONE) begin
                            state_d = (pld_n_q != '0) ? ST_PLD : ST_FLUSH;
                        end
                    end
                end
                ST_PLD: begin
                    if (s_fire) begin
                        pld_n_d = pld_n_q - ONE;
                        if (pld_n_q == ONE) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Finish as soon as the held beat leaves, so done lands one cycle after the accept.
                    if (ob_drained) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            aad_n_q     <= '0;
            pld_n_q     <= '0;
            aad_klast_q <= '0;
            pld_klast_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aad_n_q     <= aad_n_d;
            pld_n_q     <= pld_n_d;
            aad_klast_q <= aad_klast_d;
            pld_klast_q <= pld_klast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign len_err  = len_err_q;
    assign aad_data = ob_data;
    assign din_data = ob_data;
    assign aad_keep = ob_keep;
    assign din_keep = ob_keep;
    assign aad_last = ob_last && ob_sel_aad;
    assign din_last = ob_last && !ob_sel_aad;

endmodule

// File: tb/tb_aes_gcm_stream_src.sv
// Directed bench for aes_gcm_stream_src: table of length vectors plus backpressure, abort and reset sequences.
module tb_aes_gcm_stream_src;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [63:0]  len_aad_bits = '0;
    logic [63:0]  len_pld_bits = '0;
    logic         busy, done, len_err;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         aad_valid, aad_last, din_valid, din_last;
    logic         aad_ready = 1'b1;
    logic         din_ready = 1'b1;
    logic [127:0] aad_data, din_data;
    logic [15:0]  aad_keep, din_keep;

    aes_gcm_stream_src dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .len_aad_bits (len_aad_bits),
        .len_pld_bits (len_pld_bits),
        .busy         (busy),
        .done         (done),
        .len_err      (len_err),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .aad_valid    (aad_valid),
        .aad_ready    (aad_ready),
        .aad_last     (aad_last),
        .aad_data     (aad_data),
        .aad_keep     (aad_keep),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .din_last     (din_last),
        .din_data     (din_data),
        .din_keep     (din_keep)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] la;
        logic [63:0] lp;
        bit          err;
        int          n_aad;
        int          n_pld;
        logic [15:0] ka;
        logic [15:0] kp;
    } vec_t;

    vec_t vecs[9];
    int checks = 0;
    int errors = 0;

    logic [127:0] aq_d[$];
    logic [15:0]  aq_k[$];
    logic         aq_l[$];
    logic [127:0] dq_d[$];
    logic [15:0]  dq_k[$];
    logic         dq_l[$];

    function automatic logic [127:0] src_beat(input int tag, input int i);
        logic [31:0] w;
        w = 32'h5A000000 + 32'(tag * 256 + i);
        return {w, w, w, w};
    endfunction

    function automatic logic [127:0] exp_data(input logic [127:0] d, input logic [15:0] k);
        logic [127:0] r;
        r = d;
`ifdef AES_GCM_SRC_MASK_EN
        for (int b = 0; b < 16; b++) begin
            if (!k[b]) r[b*8 +: 8] = 8'h00;
        end
`else
        if (k == 16'h0) r = d;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] la, input logic [63:0] lp);
        @(negedge clk);
        len_aad_bits = la;
        len_pld_bits = lp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int tag, input bit bp, input int budget);
        int nsent, total, done_cyc, last_out, first_s, last_s;
        bit got_done, pa_stall, pd_stall;
        logic [127:0] pa_d, pd_d;
        logic [15:0] pa_k, pd_k;
        logic pa_l, pd_l;
        logic [15:0] k;
        aq_d.delete(); aq_k.delete(); aq_l.delete();
        dq_d.delete(); dq_k.delete(); dq_l.delete();
        applyStimulus(v.la, v.lp);
        if (v.err) begin
            s_valid = 1'b1;
            s_data = src_beat(tag, 0);
            #1;
            checkOutput("err_pulse", len_err, 1);
            checkOutput("err_busy", busy, 0);
            checkOutput("err_sready", s_ready, 0);
            @(negedge clk);
            #1;
            checkOutput("err_pulse_end", len_err, 0);
            checkOutput("err_busy2", busy, 0);
            checkOutput("err_sready2", s_ready, 0);
            checkOutput("err_valids", {aad_valid, din_valid}, 0);
            s_valid = 1'b0;
            return;
        end
        total = v.n_aad + v.n_pld;
        nsent = 0; got_done = 0; done_cyc = -1; last_out = -1; first_s = -1; last_s = -1;
        pa_stall = 0; pd_stall = 0;
        pa_d = '0; pd_d = '0; pa_k = '0; pd_k = '0; pa_l = 0; pd_l = 0;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) @(negedge clk);
            aad_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            din_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = (nsent < total);
            s_data = src_beat(tag, nsent);
            #1;
            if (c == 0) checkOutput("busy_run", busy, 1);
            if (done) begin
                got_done = 1;
                done_cyc = c;
                checkOutput("busy_at_done", busy, 0);
                break;
            end
            checkOutput("one_valid", aad_valid & din_valid, 0);
            if (pa_stall) begin
                checkOutput("aad_hold", {aad_valid, aad_last, aad_keep, aad_data}, {1'b1, pa_l, pa_k, pa_d});
            end
            if (pd_stall) begin
                checkOutput("din_hold", {din_valid, din_last, din_keep, din_data}, {1'b1, pd_l, pd_k, pd_d});
            end
            pa_stall = aad_valid && !aad_ready;
            pd_stall = din_valid && !din_ready;
            pa_d = aad_data; pa_k = aad_keep; pa_l = aad_last;
            pd_d = din_data; pd_k = din_keep; pd_l = din_last;
            if (s_valid && s_ready) begin
                if (first_s < 0) first_s = c;
                last_s = c;
                nsent++;
            end
            if (aad_valid && aad_ready) begin
                aq_d.push_back(aad_data); aq_k.push_back(aad_keep); aq_l.push_back(aad_last);
                last_out = c;
            end
            if (din_valid && din_ready) begin
                dq_d.push_back(din_data); dq_k.push_back(din_keep); dq_l.push_back(din_last);
                last_out = c;
            end
        end
        s_valid = 1'b0;
        aad_ready = 1'b1;
        din_ready = 1'b1;
        if (!got_done) begin
            checkOutput("done_timeout", 0, 1);
        end
        checkOutput("aad_count", aq_d.size(), v.n_aad);
        checkOutput("din_count", dq_d.size(), v.n_pld);
        for (int i = 0; i < aq_d.size() && i < v.n_aad; i++) begin
            k = (i == v.n_aad - 1) ? v.ka : 16'hFFFF;
            checkOutput("aad_keep", aq_k[i], k);
            checkOutput("aad_last", aq_l[i], (i == v.n_aad - 1));
            checkOutput("aad_data", aq_d[i], exp_data(src_beat(tag, i), k));
        end
        for (int i = 0; i < dq_d.size() && i < v.n_pld; i++) begin
            k = (i == v.n_pld - 1) ? v.kp : 16'hFFFF;
            checkOutput("din_keep", dq_k[i], k);
            checkOutput("din_last", dq_l[i], (i == v.n_pld - 1));
            checkOutput("din_data", dq_d[i], exp_data(src_beat(tag, v.n_aad + i), k));
        end
        if (got_done) begin
            if (total > 0) checkOutput("done_latency", done_cyc, last_out + 1);
            else checkOutput("done_latency", done_cyc, 1);
            @(negedge clk);
            #1;
            checkOutput("done_single", done, 0);
        end
        if (!bp && total > 0) begin
            checkOutput("throughput", last_s - first_s, total - 1);
            checkOutput("out_latency", last_out, last_s + 1);
        end
    endtask

    task automatic kill_mid_pld(input bit use_reset, input int tag);
        applyStimulus(64'd0, 64'd512);
        aad_ready = 1'b0;
        din_ready = 1'b0;
        s_valid = 1'b1;
        s_data = src_beat(tag, 0);
        @(negedge clk);
        #1;
        checkOutput("kill_pre_valid", din_valid, 1);
        s_valid = 1'b0;
        if (use_reset) rst_n = 1'b0;
        else abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("kill_valids", {aad_valid, din_valid}, 0);
        checkOutput("kill_busy", busy, 0);
        checkOutput("kill_sready", s_ready, 0);
        checkOutput("kill_outreg", {din_last, din_keep, din_data}, 0);
        rst_n = 1'b1;
        din_ready = 1'b1;
        aad_ready = 1'b1;
        run_vector(vecs[0], tag + 1, 1'b0, 200);
    endtask

    initial begin
        vecs[0] = '{64'd160, 64'd256, 1'b0, 2, 2, 16'hF000, 16'hFFFF};
        vecs[1] = '{64'd0,   64'd8,   1'b0, 0, 1, 16'hFFFF, 16'h8000};
        vecs[2] = '{64'd8,   64'd0,   1'b0, 1, 0, 16'h8000, 16'hFFFF};
        vecs[3] = '{64'd0,   64'd12,  1'b1, 0, 0, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{64'd0,   64'd0,   1'b0, 0, 0, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{64'd128, 64'd136, 1'b0, 1, 2, 16'hFFFF, 16'h8000};
        vecs[6] = '{64'd20,  64'd0,   1'b1, 0, 0, 16'hFFFF, 16'hFFFF};
        vecs[7] = '{64'h0000_0080_0000_0000, 64'd0, 1'b1, 0, 0, 16'hFFFF, 16'hFFFF};
        vecs[8] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 0, 0, 16'hFFFF, 16'hFFFF};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_status", {busy, done, len_err, s_ready}, 0);
        checkOutput("reset_valids", {aad_valid, din_valid, aad_last, din_last}, 0);
        checkOutput("reset_data", {aad_keep, din_keep, aad_data}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            $display("[TB] vector %0d: aad=%0d pld=%0d", i, vecs[i].la, vecs[i].lp);
            run_vector(vecs[i], i + 1, 1'b0, 200);
        end

        $display("[TB] random backpressure over 37 blocks");
        begin
            vec_t bpv;
            bpv = '{64'd1832, 64'd2816, 1'b0, 15, 22, 16'hF800, 16'hFFFF};
            run_vector(bpv, 20, 1'b1, 2000);
        end

        $display("[TB] largest accepted AAD length");
        applyStimulus(64'h0000_007F_FFFF_FF80, 64'd0);
        #1;
        checkOutput("max_len_err", len_err, 0);
        checkOutput("max_len_busy", busy, 1);
        s_valid = 1'b1;
        s_data = src_beat(25, 0);
        @(negedge clk);
        #1;
        checkOutput("max_len_beat", {aad_valid, aad_last, aad_keep}, {1'b1, 1'b0, 16'hFFFF});
        s_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("max_len_abort", {busy, aad_valid, din_valid}, 0);

        $display("[TB] abort mid payload");
        kill_mid_pld(1'b0, 30);
        $display("[TB] reset mid payload");
        kill_mid_pld(1'b1, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
